axi_slice_buffer: RTL and testbench
===================================

// Module: axi_slice_buffer
// PURPOSE
//  Parametrised elastic buffer for one AXI channel (AW/W/AR/R/B payload as flat vector).
//  Successor of the single-entry slice: any DEPTH incl. non-power-of-two, optional fall-through,
//  occupancy output, sync flush, and push/pop gated by the full valid/ready handshake.
//  Instantiated per channel inside the AXI slice wrappers between master and slave ports.
// PARAMETERS
//  DATA_WIDTH    64   payload width in bits, >=1
//  BUFFER_DEPTH  2    entries; 0 = combinational pass-through (wires only), 1..256 otherwise
//  FALL_THROUGH  1'b0 1: data_i visible at data_o in the same cycle when buffer is empty
//  CNT_WIDTH     derived: $clog2(BUFFER_DEPTH+1), min 1 (localparam, not overridable)
// PORTS
//  clk_i       in   1           clock, rising edge
//  rst_ni      in   1           asynchronous reset, active-low
//  testmode_i  in   1           DFT; no functional effect, routed to any clock-gating cell
//  flush_i     in   1           synchronous clear of all entries
//  valid_i     in   1           upstream valid
//  ready_o     out  1           upstream ready
//  data_i      in   DATA_WIDTH  upstream payload
//  valid_o     out  1           downstream valid
//  ready_i     in   1           downstream ready
//  data_o      out  DATA_WIDTH  downstream payload
//  usage_o     out  CNT_WIDTH   entries currently held (0..BUFFER_DEPTH)
// BEHAVIOUR
//  - Reset: valid_o=0, ready_o=1, usage_o=0, rd/wr pointers=0, storage cleared to '0, data_o='0.
//  - push = valid_i & ready_o; pop = valid_o & ready_i. Never push when ready_o=0, regardless of valid_i.
//  - ready_o = (usage != BUFFER_DEPTH); registered-state only, never combinationally from ready_i.
//  - FALL_THROUGH=0: valid_o = (usage != 0); data_o = mem[rd_ptr]; min latency 1 cycle in -> out.
//  - FALL_THROUGH=1 and usage==0: valid_o=valid_i, data_o=data_i; if ready_i=1 the beat passes
//    with 0 latency and is not stored (usage stays 0); if ready_i=0 it is stored as normal.
//  - Pointers increment modulo BUFFER_DEPTH (explicit wrap at DEPTH-1, no power-of-2 reliance).
//  - Counter: push&!pop -> +1; pop&!push -> -1; push&pop -> unchanged, both pointers advance.
//  - Full with pop in same cycle: ready_o is 0 that cycle (no combinational slot reuse);
//    entry becomes free next cycle. Throughput at DEPTH>=2 is 1 beat/cycle.
//  - DEPTH=1, FALL_THROUGH=0: half throughput (1 beat / 2 cycles) - documented, accepted.
//  - flush_i=1: next cycle usage=0, pointers=0, valid_o=0 (FT=1: valid_o may follow valid_i
//    combinationally, but no push/pop state update happens in the flush cycle).
//    Flush beats push and pop; beats accepted in that cycle are dropped, upstream sees ready_o.
//  - BUFFER_DEPTH=0: ready_o=ready_i, valid_o=valid_i, data_o=data_i, usage_o=0; flush ignored.
//  - Reset asserted mid-transfer: all state returns to reset values asynchronously; in-flight
//    contents lost; no X on any output during or after reset.
//  - Assertions: no push while usage==DEPTH; no pop while valid_o=0; valid_o held until pop and
//    data_o stable while valid_o & !ready_i (AXI stability rule); param range checks at elaboration.
// STRUCTURE
//  - axi_slice_pkg: slice_mode_e {SLICE_BYPASS, SLICE_REG, SLICE_FT}, MAX_DEPTH=256,
//    function cnt_width(depth) shared with channel wrappers.
//  - Sub-module axi_slice_ptr #(DEPTH): wrap-around pointer with en_i, clr_i, ptr_o; used twice.
//  - Storage as flop array (no SRAM macro); generate branch for BUFFER_DEPTH==0.
// TESTING
//  1 DEPTH=4,FT=0: push 0xA1..0xA4 with ready_i=0 -> usage 4, ready_o=0; 5th valid_i not taken;
//    ready_i=1 -> out 0xA1,0xA2,0xA3,0xA4 on consecutive cycles, usage 0.
//  2 DEPTH=3,FT=0: stream 10 beats, ready_i=1 -> one beat/cycle after 1-cycle latency,
//    pointer wrap 2->0 verified, order preserved.
//  3 DEPTH=2,FT=1: empty, valid_i=1,data 0x55,ready_i=1 -> same-cycle valid_o=1,data_o=0x55,
//    usage stays 0; repeat with ready_i=0 -> stored, usage 1.
//  4 DEPTH=4: fill 3 entries, flush_i=1 with valid_i=1 -> next cycle usage 0, valid_o=0,
//    that beat dropped; following beat 0x77 emerges first.
//  5 DEPTH=2: usage 2, push+pop same cycle attempt -> pop only, ready_o=0 that cycle, usage 1.
//  6 Random valid/ready (50%), DEPTH in {0,1,5,8}, both FT; async reset mid-burst ->
//    scoreboard order-exact, outputs at reset values immediately, assertions clean.

Source files
------------

// File: rtl/axi_slice_pkg.sv
// Shared types and sizing helpers for the AXI channel slice buffers and their wrappers.
package axi_slice_pkg;

   typedef enum logic [1:0] {SLICE_BYPASS, SLICE_REG, SLICE_FT} slice_mode_e;

   localparam int unsigned MAX_DEPTH = 256;

   function automatic int unsigned cnt_width(input int unsigned depth);
      int unsigned w;
      w = $clog2(depth + 1);
      return (w == 0) ? 1 : w;
   endfunction

   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic slice_mode_e slice_mode(input int unsigned depth, input bit ft);
      if (depth == 0) return SLICE_BYPASS;
      else if (ft)    return SLICE_FT;
      else            return SLICE_REG;
   endfunction

endpackage

// File: rtl/axi_slice_ptr.sv
// Wrap-around index for the slice buffer; wraps explicitly at DEPTH-1 so any depth works.
module axi_slice_ptr
   import axi_slice_pkg::*;
#(
   parameter int unsigned  DEPTH = 2,
   localparam int unsigned PTR_W = ptr_width(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic             clr_i,
   output logic [PTR_W-1:0] ptr_o
);

   logic [PTR_W-1:0] ptr_d, ptr_q;

   always_comb begin
      ptr_d = ptr_q;
      if (clr_i) begin
         ptr_d = '0;
      end else if (en_i) begin
         ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) ptr_q <= '0;
      else         ptr_q <= ptr_d;
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/axi_slice_buffer.sv
// Elastic buffer for one AXI channel: flop-array FIFO of any depth, optional fall-through,
// occupancy output and synchronous flush; depth 0 degenerates to plain wires.
module axi_slice_buffer
   import axi_slice_pkg::*;
#(
   parameter int unsigned  DATA_WIDTH   = 64,
   parameter int unsigned  BUFFER_DEPTH = 2,
   parameter bit           FALL_THROUGH = 1'b0,
   localparam int unsigned CNT_WIDTH    = cnt_width(BUFFER_DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  testmode_i,
   input  logic                  flush_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic [CNT_WIDTH-1:0]  usage_o
);

   localparam slice_mode_e MODE = slice_mode(BUFFER_DEPTH, FALL_THROUGH);

   if (DATA_WIDTH < 1) begin : g_bad_width
      $error("axi_slice_buffer: DATA_WIDTH must be >= 1");
   end
   if (BUFFER_DEPTH > MAX_DEPTH) begin : g_bad_depth
      $error("axi_slice_buffer: BUFFER_DEPTH must be <= %0d", MAX_DEPTH);
   end

   // No clock gating inside this block, so the DFT pin has nothing to drive.
   logic unused_testmode;
   assign unused_testmode = testmode_i;

   if (MODE == SLICE_BYPASS) begin : g_bypass
      logic unused_ctrl;
      assign unused_ctrl = ^{clk_i, rst_ni, flush_i};
      assign ready_o     = ready_i;
      assign valid_o     = valid_i;
      assign data_o      = data_i;
      assign usage_o     = '0;
   end else begin : g_buffer
      localparam int unsigned PTR_W = ptr_width(BUFFER_DEPTH);
      // A single-entry buffer still needs a 1-bit index; the spare row is never written.
      localparam int unsigned MEM_N = (BUFFER_DEPTH > 1) ? BUFFER_DEPTH : 2;

      logic [DATA_WIDTH-1:0] mem_d [MEM_N];
      logic [DATA_WIDTH-1:0] mem_q [MEM_N];
      logic [CNT_WIDTH-1:0]  usage_d, usage_q;
      logic [PTR_W-1:0]      rd_ptr, wr_ptr;
      logic                  full, empty, ft_empty;
      logic                  push, pop, bypass, store, take;

      assign full     = (usage_q == CNT_WIDTH'(BUFFER_DEPTH));
      assign empty    = (usage_q == '0);
      assign ft_empty = (MODE == SLICE_FT) && empty;

      assign ready_o = !full;
      assign valid_o = ft_empty ? valid_i : !empty;
      assign data_o  = ft_empty ? data_i  : mem_q[rd_ptr];
      assign usage_o = usage_q;

      assign push   = valid_i && ready_o;
      assign pop    = valid_o && ready_i;
      // A fall-through beat consumed in the same cycle never touches the storage.
      assign bypass = ft_empty && push && ready_i;
      assign store  = push && !bypass && !flush_i;
      assign take   = pop  && !bypass && !flush_i;

      always_comb begin
         usage_d = usage_q;
         if (flush_i) begin
            usage_d = '0;
         end else if (store && !take) begin
            usage_d = usage_q + CNT_WIDTH'(1);
         end else if (take && !store) begin
            usage_d = usage_q - CNT_WIDTH'(1);
         end
      end

      always_comb begin
         mem_d = mem_q;
         if (store) mem_d[wr_ptr] = data_i;
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            usage_q <= '0;
            mem_q   <= '{default: '0};
         end else begin
            usage_q <= usage_d;
            mem_q   <= mem_d;
         end
      end

      axi_slice_ptr #(.DEPTH(BUFFER_DEPTH)) u_wr_ptr (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .en_i   (store),
         .clr_i  (flush_i),
         .ptr_o  (wr_ptr)
      );

      axi_slice_ptr #(.DEPTH(BUFFER_DEPTH)) u_rd_ptr (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .en_i   (take),
         .clr_i  (flush_i),
         .ptr_o  (rd_ptr)
      );

      a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
         !(push && full));
      a_no_pop_invalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
         pop |-> valid_o);
      // Stored beats must stay put until taken; only flush or reset may retract them.
      a_hold_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
         (valid_o && !ready_i && !flush_i && !empty) |=> (valid_o && $stable(data_o)));
   end

endmodule

// File: tb/tb_axi_slice_buffer.sv
// Drives one shared stimulus into several buffer configurations and checks each against a
// queue-based reference model every cycle, plus directed scenarios with literal expectations.
module tb_axi_slice_buffer;
   import axi_slice_pkg::*;

   localparam int DW = 16;
   localparam int NC = 11;
   localparam int DEP [NC] = '{0, 1, 1, 2, 2, 3, 4, 5, 8, 8, 5};
   localparam bit FTS [NC] = '{0, 0, 1, 0, 1, 0, 0, 1, 0, 1, 0};

   logic          clk, rst_n, testmode, flush, valid_i, ready_i;
   logic [DW-1:0] data_i;
   logic [NC-1:0] ready_o_v, valid_o_v;
   logic [DW-1:0] data_o_a [NC];
   logic [31:0]   usage_a  [NC];

   logic [DW-1:0] q [NC][$];
   int            n_tests, n_fail;

   for (genvar g = 0; g < NC; g++) begin : g_dut
      localparam int CW = cnt_width(DEP[g]);
      logic [CW-1:0] usage_w;
      axi_slice_buffer #(
         .DATA_WIDTH   (DW),
         .BUFFER_DEPTH (DEP[g]),
         .FALL_THROUGH (FTS[g])
      ) u_dut (
         .clk_i      (clk),
         .rst_ni     (rst_n),
         .testmode_i (testmode),
         .flush_i    (flush),
         .valid_i    (valid_i),
         .ready_o    (ready_o_v[g]),
         .data_i     (data_i),
         .valid_o    (valid_o_v[g]),
         .ready_i    (ready_i),
         .data_o     (data_o_a[g]),
         .usage_o    (usage_w)
      );
      assign usage_a[g] = 32'(usage_w);
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: what a FIFO of the given depth must present, from its current contents.
   task automatic model_outs(input int c, output bit ev, output bit er,
                             output logic [DW-1:0] ed, output int eu);
      int n;
      n = q[c].size();
      if (DEP[c] == 0) begin
         ev = valid_i; er = ready_i; ed = data_i; eu = 0;
      end else begin
         er = (n != DEP[c]);
         eu = n;
         if (FTS[c] && n == 0) begin
            ev = valid_i; ed = data_i;
         end else begin
            ev = (n != 0); ed = (n != 0) ? q[c][0] : '0;
         end
      end
   endtask

   task automatic compare_all();
      bit ev, er;
      logic [DW-1:0] ed;
      int eu;
      for (int c = 0; c < NC; c++) begin
         model_outs(c, ev, er, ed, eu);
         check($sformatf("cfg%0d ready_o", c), 32'(ready_o_v[c]), 32'(er));
         check($sformatf("cfg%0d valid_o", c), 32'(valid_o_v[c]), 32'(ev));
         check($sformatf("cfg%0d usage_o", c), usage_a[c], eu);
         if (ev) check($sformatf("cfg%0d data_o", c), 32'(data_o_a[c]), 32'(ed));
      end
   endtask

   task automatic model_update();
      bit ev, er, push, pop;
      logic [DW-1:0] ed;
      int eu;
      for (int c = 0; c < NC; c++) begin
         if (DEP[c] == 0) continue;
         if (!rst_n || flush) begin
            q[c].delete();
            continue;
         end
         model_outs(c, ev, er, ed, eu);
         push = valid_i && er;
         pop  = ev && ready_i;
         if (FTS[c] && eu == 0 && push && ready_i) continue;
         if (pop)  void'(q[c].pop_front());
         if (push) q[c].push_back(data_i);
      end
   endtask

   task automatic step();
      @(negedge clk);
      compare_all();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic drive(input bit v, input logic [DW-1:0] d, input bit r, input bit f);
      valid_i = v; data_i = d; ready_i = r; flush = f;
   endtask

   task automatic do_reset();
      drive(0, '0, 0, 0);
      rst_n = 1'b0;
      for (int c = 0; c < NC; c++) q[c].delete();
      step();
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      n_tests = 0; n_fail = 0;
      testmode = 1'b0;
      rst_n = 1'b0;
      drive(0, '0, 0, 0);
      @(posedge clk); #1;
      step();
      // reset values on a registered instance (depth 4)
      check("reset usage", usage_a[6], 0);
      check("reset ready_o", 32'(ready_o_v[6]), 1);
      check("reset valid_o", 32'(valid_o_v[6]), 0);
      check("reset data_o", 32'(data_o_a[6]), 0);
      rst_n = 1'b1;

      // fill depth 4, fifth beat refused, then drain in order
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1, DW'(16'hA1 + i), 0, 0);
         step();
      end
      check("t1 usage full", usage_a[6], 4);
      check("t1 ready_o full", 32'(ready_o_v[6]), 0);
      drive(1, 16'hA5, 0, 0);
      step();
      check("t1 fifth refused", usage_a[6], 4);
      drive(0, '0, 1, 0);
      for (int i = 0; i < 4; i++) begin
         #1;
         check("t1 drain valid", 32'(valid_o_v[6]), 1);
         check("t1 drain data", 32'(data_o_a[6]), 32'(16'hA1 + i));
         step();
      end
      check("t1 drained usage", usage_a[6], 0);

      // depth 3 streaming: one beat per cycle, pointers wrap repeatedly
      do_reset();
      for (int i = 0; i < 10; i++) begin
         drive(1, DW'(16'h10 + i), 1, 0);
         #1;
         if (i > 0) begin
            check("t2 stream valid", 32'(valid_o_v[5]), 1);
            check("t2 stream data", 32'(data_o_a[5]), 32'(16'h10 + i - 1));
         end
         step();
      end
      drive(0, '0, 1, 0);
      #1;
      check("t2 last data", 32'(data_o_a[5]), 32'h19);
      step();
      check("t2 empty", usage_a[5], 0);

      // depth 2 fall-through: zero-latency pass, then stored when stalled
      do_reset();
      drive(1, 16'h55, 1, 0);
      #1;
      check("t3 ft valid", 32'(valid_o_v[4]), 1);
      check("t3 ft data", 32'(data_o_a[4]), 32'h55);
      check("t3 ft usage", usage_a[4], 0);
      step();
      check("t3 not stored", usage_a[4], 0);
      drive(1, 16'h55, 0, 0);
      step();
      check("t3 stored", usage_a[4], 1);

      // flush with a concurrent beat: beat dropped, next beat first out
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1, DW'(16'h31 + i), 0, 0);
         step();
      end
      drive(1, 16'h66, 0, 1);
      step();
      drive(0, '0, 0, 0);
      #1;
      check("t4 flush usage", usage_a[6], 0);
      check("t4 flush valid", 32'(valid_o_v[6]), 0);
      drive(1, 16'h77, 0, 0);
      step();
      drive(0, '0, 1, 0);
      #1;
      check("t4 next valid", 32'(valid_o_v[6]), 1);
      check("t4 next data", 32'(data_o_a[6]), 32'h77);
      step();

      // depth 2 full with push+pop offered: only the pop happens
      do_reset();
      drive(1, 16'h51, 0, 0); step();
      drive(1, 16'h52, 0, 0); step();
      drive(1, 16'h53, 1, 0);
      #1;
      check("t5 ready_o full", 32'(ready_o_v[3]), 0);
      check("t5 head", 32'(data_o_a[3]), 32'h51);
      step();
      check("t5 usage", usage_a[3], 1);
      check("t5 next head", 32'(data_o_a[3]), 32'h52);

      // random traffic with occasional flush and async reset mid-burst
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         drive(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 31) == 0));
         if (i % 750 == 700) begin
            #1;
            rst_n = 1'b0;
            for (int c = 0; c < NC; c++) q[c].delete();
            #1;
            check("async rst usage d8", usage_a[8], 0);
            check("async rst ready d8", 32'(ready_o_v[8]), 1);
            check("async rst valid d8", 32'(valid_o_v[8]), 0);
            check("async rst data d8", 32'(data_o_a[8]), 0);
            step();
            rst_n = 1'b1;
         end else begin
            step();
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
